alu_scheduler: RTL and testbench
================================

Name: alu_scheduler

Overview:
Round-robin arbiter and sequencer that shares the single combinational control_unit ALU between two requesters. Each requester submits a 19-bit incode (opcode[18:16], operand A[15:8], operand B[7:0]) over a valid/ready handshake. The scheduler registers the winning incode onto the ALU input and waits a programmable settle time. It then captures the 8-bit answer and returns it on a response channel tagged with the requester id. It sits between instruction sources (fetch, test sequencer) and the ALU.

Parameters:
SETTLE_CYCLES, 1, cycles the registered incode is held before ans is sampled (legal 1..15)
CNT_W, 16, width of the completed-operation counter

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous active-low reset
r0_valid  in  1  requester 0 has an op
r0_ready  out  1  requester 0 op accepted this cycle
r0_incode  in  19  requester 0 incode
r1_valid  in  1  requester 1 has an op
r1_ready  out  1  requester 1 op accepted this cycle
r1_incode  in  19  requester 1 incode
alu_incode  out  19  registered incode driven to control_unit.incode
alu_ans  in  8  control_unit.ans
rsp_valid  out  1  response available
rsp_ready  in  1  response consumer ready
rsp_id  out  1  requester that issued the op
rsp_ans  out  8  captured ALU result
busy  out  1  high in any state other than IDLE
done_cnt  out  CNT_W  completed responses, saturating

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE. alu_incode=0, rsp_valid=0, rsp_id=0, rsp_ans=0, done_cnt=0, last_grant=1 (so r0 wins the first tie). Reset mid-operation abandons the op; no response is produced.
- States: IDLE -> SETTLE -> RESP -> IDLE.
- IDLE:
  - Grant logic is combinational from rx_valid and last_grant. Only one ready may be high. A ready is never high outside IDLE.
  - Only r0_valid: r0_ready=1. Only r1_valid: r1_ready=1.
  - Both valid: grant the requester != last_grant.
  - On accept: alu_incode <= granted incode, rsp_id <= granted id, last_grant <= granted id, settle counter <= SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - alu_incode is held stable.
  - While counter != 0: decrement.
  - When counter == 0: rsp_ans <= alu_ans, rsp_valid <= 1, go to RESP.
  - Accept at edge t gives rsp_valid high from edge t+SETTLE_CYCLES.
- RESP:
  - rsp_valid, rsp_id, rsp_ans and alu_incode are all held until rsp_ready=1.
  - On that edge: rsp_valid <= 0, done_cnt increments (saturates at all-ones), go to IDLE.
  - The next accept occurs at the earliest on the edge after this handshake, so there is no back-to-back issue. Throughput is one op per SETTLE_CYCLES+2 cycles minimum.
- Requester-side rules:
  - Requester inputs are ignored when not granted.
  - A requester that drops valid before acceptance loses nothing.
  - The incode is sampled only on the accept edge; changes afterwards do not affect the op in flight.
- alu_incode keeps its last value in IDLE; it is not cleared.
- All opcodes, including 3'b000, are issued unmodified; the scheduler never decodes them.
- busy = (state != IDLE).

Decomposition:
- Shared package alu_pkg:
  - incode field localparams: OPC_MSB=18, OPC_LSB=16, A_MSB=15, A_LSB=8, B_MSB=7, B_LSB=0, INCODE_W=19, ANS_W=8.
  - state enum encoding: IDLE=2'd0, SETTLE=2'd1, RESP=2'd2.
- Sub-module rr_arb2: 2-way round-robin grant from valid[1:0] and last_grant, giving grant one-hot and grant id. Combinational, reusable.
- control_unit is instantiated by the parent, not inside the scheduler.

Test Plan:
- Bench ALU stub: ans = A ^ B. Reset held 2 cycles, then released -> all outputs 0, busy=0, r0_ready=r1_ready=0 with no valids.
- Single op: r0 sends 19'b0010010001100010110 (A=0x23, B=0x16), SETTLE_CYCLES=1, rsp_ready=1 -> r0_ready one cycle; alu_incode=that value; rsp_valid from accept+1 edge; rsp_id=0, rsp_ans=0x35; done_cnt=1.
- Tie: r0 and r1 both valid continuously, with opcodes 010 and 011 (same A/B) -> grant order r0, r1, r0, r1; rsp_id alternates 0,1,0,1; never two readies in one cycle.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid/rsp_ans/rsp_id stable; r0_ready and r1_ready stay 0; handshake on cycle 6, then next accept one edge later.
- SETTLE_CYCLES=4: the stub changes ans only after 3 cycles -> captured value is the post-change value; rsp_valid rises exactly 4 edges after accept.
- Reset mid-op: assert rst_n=0 while in SETTLE -> next cycle IDLE, rsp_valid=0, done_cnt=0. Saturation: force done_cnt to all-ones, complete one op -> stays 0xFFFF.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler: incode field layout and FSM states.
package alu_pkg;

    // Incode layout: opcode[18:16], operand A[15:8], operand B[7:0].
    localparam int OPC_MSB  = 18;
    localparam int OPC_LSB  = 16;
    localparam int A_MSB    = 15;
    localparam int A_LSB    = 8;
    localparam int B_MSB    = 7;
    localparam int B_LSB    = 0;
    localparam int INCODE_W = 19;
    localparam int ANS_W    = 8;

    // Scheduler sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/alu_scheduler_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant plus grant id, purely combinational.
module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_last_grant,
    output logic [1:0] o_grant,
    output logic       o_grant_id
);

    // Single winner per cycle; on a tie the requester that did not win last time goes.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        o_grant    = 2'b00;
        o_grant_id = 1'b0;
        case (i_valid)
            2'b01: begin
                o_grant    = 2'b01;
                o_grant_id = 1'b0;
            end
            2'b10: begin
                o_grant    = 2'b10;
                o_grant_id = 1'b1;
            end
            2'b11: begin
                if (i_last_grant) begin
                    o_grant    = 2'b01;
                    o_grant_id = 1'b0;
                end else begin
                    o_grant    = 2'b10;
                    o_grant_id = 1'b1;
                end
            end
            default: begin
                o_grant    = 2'b00;
                o_grant_id = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one combinational ALU between two requesters: arbitrate, hold the
// incode for SETTLE_CYCLES, capture the answer and return it tagged with the id.
module alu_scheduler
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                r0_valid,
    output logic                r0_ready,
    input  logic [INCODE_W-1:0] r0_incode,
    input  logic                r1_valid,
    output logic                r1_ready,
    input  logic [INCODE_W-1:0] r1_incode,
    output logic [INCODE_W-1:0] alu_incode,
    input  logic [ANS_W-1:0]    alu_ans,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [ANS_W-1:0]    rsp_ans,
    output logic                busy,
    output logic [CNT_W-1:0]    done_cnt
);

    // Counter preload: accept at edge t, capture at edge t+SETTLE_CYCLES.
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_settle_cnt;
    logic                  r_last_grant;
    logic [INCODE_W-1:0]   r_alu_incode;
    logic                  r_rsp_id;
    logic [ANS_W-1:0]      r_rsp_ans;
    logic [CNT_W-1:0]      r_done_cnt;

    logic [1:0]            w_valid;
    logic [1:0]            w_grant;
    logic                  w_grant_id;
    logic                  w_accept;

    // Requests are only visible to the arbiter in IDLE, so no ready outside it.
    assign w_valid  = {r1_valid, r0_valid} & {2{r_state == IDLE}};
    assign w_accept = |w_grant;

    rr_arb2 u_arb (
        .i_valid      (w_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_id   (w_grant_id)
    );

    assign r0_ready   = w_grant[0];
    assign r1_ready   = w_grant[1];
    assign alu_incode = r_alu_incode;
    assign rsp_valid  = (r_state == RESP);
    assign rsp_id     = r_rsp_id;
    assign rsp_ans    = r_rsp_ans;
    assign busy       = (r_state != IDLE);
    assign done_cnt   = r_done_cnt;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state decode: accept -> settle countdown -> wait for response handshake.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)              w_state_next = SETTLE;
            SETTLE:  if (r_settle_cnt == 4'd0)  w_state_next = RESP;
            RESP:    if (rsp_ready)             w_state_next = IDLE;
            default:                            w_state_next = IDLE;
        endcase
    end

    // Datapath: latch the granted op, count down, capture the answer, count completions.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alu_incode <= '0;
            r_rsp_id     <= 1'b0;
            r_rsp_ans    <= '0;
            r_last_grant <= 1'b1;
            r_settle_cnt <= 4'd0;
            r_done_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_alu_incode <= w_grant_id ? r1_incode : r0_incode;
                        r_rsp_id     <= w_grant_id;
                        r_last_grant <= w_grant_id;
                        r_settle_cnt <= SETTLE_INIT;
                    end
                end
                SETTLE: begin
                    if (r_settle_cnt != 4'd0) r_settle_cnt <= r_settle_cnt - 4'd1;
                    else                      r_rsp_ans    <= alu_ans;
                end
                RESP: begin
                    if (rsp_ready && (r_done_cnt != '1)) r_done_cnt <= r_done_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_scheduler.sv
// Self-checking bench: two scheduler instances (settle 1 / settle 4 with a
// narrow counter), XOR ALU stubs, and per-instance response scoreboards.
module tb_alu_scheduler;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance A: SETTLE_CYCLES=1, 16-bit counter
    logic        v0_a, v1_a, rrdy_a, rdy0_a, rdy1_a, rv_a, rid_a, busy_a;
    logic [18:0] inc0_a, inc1_a, alu_inc_a;
    logic [7:0]  ans_a, rans_a;
    logic [15:0] cnt_a;

    // Instance B: SETTLE_CYCLES=4, 2-bit counter so saturation is reachable
    logic        v0_b, v1_b, rrdy_b, rdy0_b, rdy1_b, rv_b, rid_b, busy_b;
    logic [18:0] inc0_b, inc1_b, alu_inc_b;
    logic [7:0]  ans_b, rans_b;
    logic [1:0]  cnt_b;

    alu_scheduler #(.SETTLE_CYCLES(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(v0_a), .r0_ready(rdy0_a), .r0_incode(inc0_a),
        .r1_valid(v1_a), .r1_ready(rdy1_a), .r1_incode(inc1_a),
        .alu_incode(alu_inc_a), .alu_ans(ans_a),
        .rsp_valid(rv_a), .rsp_ready(rrdy_a), .rsp_id(rid_a), .rsp_ans(rans_a),
        .busy(busy_a), .done_cnt(cnt_a)
    );

    alu_scheduler #(.SETTLE_CYCLES(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(v0_b), .r0_ready(rdy0_b), .r0_incode(inc0_b),
        .r1_valid(v1_b), .r1_ready(rdy1_b), .r1_incode(inc1_b),
        .alu_incode(alu_inc_b), .alu_ans(ans_b),
        .rsp_valid(rv_b), .rsp_ready(rrdy_b), .rsp_id(rid_b), .rsp_ans(rans_b),
        .busy(busy_b), .done_cnt(cnt_b)
    );

    // ALU stub A: ans = A ^ B immediately.
    assign ans_a = alu_inc_a[15:8] ^ alu_inc_a[7:0];

    // ALU stub B: shows the inverted value until 3 cycles after an accept.
    logic [3:0] age_b = 4'd15;
    always @(posedge clk) begin
        if (rdy0_b || rdy1_b)   age_b <= 4'd0;
        else if (age_b != 4'd15) age_b <= age_b + 4'd1;
    end
    assign ans_b = (age_b >= 4'd3) ? (alu_inc_b[15:8] ^ alu_inc_b[7:0])
                                   : ~(alu_inc_b[15:8] ^ alu_inc_b[7:0]);

    typedef struct packed {
        logic        id;
        logic [7:0]  ans;
        logic [18:0] incode;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;
    int   errors = 0;
    int   checks = 0;

    function automatic logic [7:0] model_ans(input logic [18:0] inc);
        return inc[15:8] ^ inc[7:0];
    endfunction

    // Scoreboard A: compare every response handshake with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rv_a && rrdy_a) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL rsp_a_unexpected: got id=%0d ans=%0h, no response expected", rid_a, rans_a);
            end else begin
                e_a = q_a.pop_front();
                if ({rid_a, rans_a, alu_inc_a} !== {e_a.id, e_a.ans, e_a.incode}) begin
                    errors++;
                    $display("FAIL rsp_a: got id=%0d ans=%0h inc=%0h, expected id=%0d ans=%0h inc=%0h",
                             rid_a, rans_a, alu_inc_a, e_a.id, e_a.ans, e_a.incode);
                end
            end
        end
    end

    // Scoreboard B.
    always @(negedge clk) begin
        if (rst_n && rv_b && rrdy_b) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL rsp_b_unexpected: got id=%0d ans=%0h, no response expected", rid_b, rans_b);
            end else begin
                e_b = q_b.pop_front();
                if ({rid_b, rans_b, alu_inc_b} !== {e_b.id, e_b.ans, e_b.incode}) begin
                    errors++;
                    $display("FAIL rsp_b: got id=%0d ans=%0h inc=%0h, expected id=%0d ans=%0h inc=%0h",
                             rid_b, rans_b, alu_inc_b, e_b.id, e_b.ans, e_b.incode);
                end
            end
        end
    end

    // Ready invariants: never both, never while busy.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ((rdy0_a && rdy1_a) || ((rdy0_a || rdy1_a) && busy_a)) begin
                errors++;
                $display("FAIL ready_a_rule: got rdy0=%0b rdy1=%0b busy=%0b, expected at most one ready and only when idle",
                         rdy0_a, rdy1_a, busy_a);
            end
            checks++;
            if ((rdy0_b && rdy1_b) || ((rdy0_b || rdy1_b) && busy_b)) begin
                errors++;
                $display("FAIL ready_b_rule: got rdy0=%0b rdy1=%0b busy=%0b, expected at most one ready and only when idle",
                         rdy0_b, rdy1_b, busy_b);
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Wait (bounded) for a ready on the selected instance; returns at the negedge before the accept edge.
    task automatic wait_accept(input bit sel, output int gid, output bit ok);
        ok  = 1'b0;
        gid = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sel ? (rdy0_b || rdy1_b) : (rdy0_a || rdy1_a)) begin
                gid = sel ? (rdy1_b ? 1 : 0) : (rdy1_a ? 1 : 0);
                ok  = 1'b1;
                return;
            end
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d/%0d responses outstanding, expected 0/0", name, q_a.size(), q_b.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (alu_inc_a !== 19'd0) begin errors++; $display("FAIL reset_alu_incode: got %0h expected 0", alu_inc_a); end
        checks++;
        if ({rv_a, rid_a, rans_a} !== 10'd0) begin
            errors++; $display("FAIL reset_rsp: got valid=%0b id=%0b ans=%0h expected all 0", rv_a, rid_a, rans_a);
        end
        checks++;
        if (cnt_a !== 16'd0) begin errors++; $display("FAIL reset_done_cnt: got %0d expected 0", cnt_a); end
        checks++;
        if ({busy_a, rdy0_a, rdy1_a} !== 3'b000) begin
            errors++; $display("FAIL reset_busy_ready: got busy=%0b r0=%0b r1=%0b expected 000", busy_a, rdy0_a, rdy1_a);
        end
        checks++;
        if ({alu_inc_b, rv_b, rans_b, cnt_b, busy_b} !== 31'd0) begin
            errors++; $display("FAIL reset_b: got inc=%0h valid=%0b ans=%0h cnt=%0d busy=%0b expected all 0",
                               alu_inc_b, rv_b, rans_b, cnt_b, busy_b);
        end
    endtask

    task automatic test_single();
        logic [18:0] op;
        int gid;
        bit ok;
        op = 19'b0010010001100010110;
        @(posedge clk); #1;
        rrdy_a = 1'b1; inc0_a = op; v0_a = 1'b1;
        wait_accept(1'b0, gid, ok);
        checks++;
        if (!ok || gid !== 0) begin errors++; $display("FAIL single_grant: got %0d expected 0 (ok=%0b)", gid, ok); end
        q_a.push_back('{id: 1'b0, ans: 8'h35, incode: op});
        @(posedge clk); #1;
        v0_a = 1'b0;
        checks++;
        if ({busy_a, rv_a, alu_inc_a} !== {1'b1, 1'b0, op}) begin
            errors++; $display("FAIL single_settle: got busy=%0b valid=%0b inc=%0h expected 1 0 %0h", busy_a, rv_a, alu_inc_a, op);
        end
        @(posedge clk); #1;
        checks++;
        if ({rv_a, rid_a, rans_a} !== {1'b1, 1'b0, 8'h35}) begin
            errors++; $display("FAIL single_rsp: got valid=%0b id=%0b ans=%0h expected 1 0 35", rv_a, rid_a, rans_a);
        end
        @(posedge clk); #1;
        checks++;
        if ({rv_a, busy_a, cnt_a} !== {1'b0, 1'b0, 16'd1}) begin
            errors++; $display("FAIL single_done: got valid=%0b busy=%0b cnt=%0d expected 0 0 1", rv_a, busy_a, cnt_a);
        end
    endtask

    task automatic test_tie();
        int gid;
        bit ok;
        int exp_id;
        do_reset();
        rrdy_a = 1'b1;
        inc0_a = {3'b010, 8'h5A, 8'hC3};
        inc1_a = {3'b011, 8'h5A, 8'hC3};
        v0_a = 1'b1; v1_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_id = k % 2;
            wait_accept(1'b0, gid, ok);
            checks++;
            if (!ok || gid !== exp_id) begin
                errors++; $display("FAIL tie_grant_%0d: got %0d expected %0d (ok=%0b)", k, gid, exp_id, ok);
            end
            q_a.push_back('{id: exp_id[0], ans: model_ans(exp_id[0] ? inc1_a : inc0_a),
                            incode: (exp_id[0] ? inc1_a : inc0_a)});
        end
        @(posedge clk); #1;
        v0_a = 1'b0; v1_a = 1'b0;
        drain("tie");
        checks++;
        if (cnt_a !== 16'd4) begin errors++; $display("FAIL tie_done_cnt: got %0d expected 4", cnt_a); end
    endtask

    task automatic test_backpressure();
        int gid;
        bit ok;
        bit seen;
        rrdy_a = 1'b0;
        inc0_a = {3'b100, 8'hF0, 8'h0F};
        inc1_a = {3'b101, 8'h12, 8'h34};
        @(posedge clk); #1;
        v0_a = 1'b1;
        wait_accept(1'b0, gid, ok);
        checks++;
        if (!ok || gid !== 0) begin errors++; $display("FAIL bp_grant: got %0d expected 0 (ok=%0b)", gid, ok); end
        q_a.push_back('{id: 1'b0, ans: 8'hFF, incode: inc0_a});
        @(posedge clk); #1;
        v0_a = 1'b0; v1_a = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = rv_a;
        end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if ({rv_a, rid_a, rans_a, rdy0_a, rdy1_a} !== {1'b1, 1'b0, 8'hFF, 2'b00}) begin
                errors++; $display("FAIL bp_hold_%0d: got valid=%0b id=%0b ans=%0h r0=%0b r1=%0b expected 1 0 ff 0 0",
                                   k, rv_a, rid_a, rans_a, rdy0_a, rdy1_a);
            end
        end
        @(posedge clk); #1;
        rrdy_a = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({rv_a, busy_a, rdy0_a, rdy1_a} !== 4'b0001) begin
            errors++; $display("FAIL bp_release: got valid=%0b busy=%0b r0=%0b r1=%0b expected 0 0 0 1",
                               rv_a, busy_a, rdy0_a, rdy1_a);
        end
        q_a.push_back('{id: 1'b1, ans: 8'h26, incode: inc1_a});
        @(posedge clk); #1;
        v1_a = 1'b0;
        checks++;
        if ({busy_a, alu_inc_a} !== {1'b1, inc1_a}) begin
            errors++; $display("FAIL bp_next_accept: got busy=%0b inc=%0h expected 1 %0h", busy_a, alu_inc_a, inc1_a);
        end
        drain("bp");
    endtask

    task automatic test_settle4();
        int gid;
        bit ok;
        logic [1:0] exp_cnt;
        rrdy_b = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk); #1;
            inc0_b = {3'(n), 8'(n * 17 + 3), 8'(n * 29 + 1)};
            v0_b = 1'b1;
            wait_accept(1'b1, gid, ok);
            checks++;
            if (!ok || gid !== 0) begin errors++; $display("FAIL s4_grant_%0d: got %0d expected 0 (ok=%0b)", n, gid, ok); end
            q_b.push_back('{id: 1'b0, ans: model_ans(inc0_b), incode: inc0_b});
            @(posedge clk); #1;
            v0_b = 1'b0;
            for (int e = 1; e <= 4; e++) begin
                @(posedge clk); #1;
                checks++;
                if (rv_b !== (e == 4)) begin
                    errors++; $display("FAIL s4_valid_%0d_edge%0d: got %0b expected %0b", n, e, rv_b, (e == 4));
                end
            end
            checks++;
            if (rans_b !== model_ans(inc0_b)) begin
                errors++; $display("FAIL s4_ans_%0d: got %0h expected %0h", n, rans_b, model_ans(inc0_b));
            end
            @(posedge clk); #1;
            exp_cnt = (n >= 2) ? 2'd3 : 2'(n + 1);
            checks++;
            if (cnt_b !== exp_cnt) begin errors++; $display("FAIL s4_done_cnt_%0d: got %0d expected %0d", n, cnt_b, exp_cnt); end
        end
        drain("s4");
    endtask

    task automatic test_reset_midop();
        int gid;
        bit ok;
        rrdy_b = 1'b1;
        @(posedge clk); #1;
        inc0_b = {3'b111, 8'hAA, 8'h55};
        v0_b = 1'b1;
        wait_accept(1'b1, gid, ok);
        checks++;
        if (!ok || gid !== 0) begin errors++; $display("FAIL midop_grant: got %0d expected 0 (ok=%0b)", gid, ok); end
        @(posedge clk); #1;
        v0_b = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy_b !== 1'b1) begin errors++; $display("FAIL midop_busy: got %0b expected 1", busy_b); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({busy_b, rv_b, cnt_b, cnt_a} !== 20'd0) begin
            errors++; $display("FAIL midop_reset: got busy=%0b valid=%0b cnt_b=%0d cnt_a=%0d expected all 0",
                               busy_b, rv_b, cnt_b, cnt_a);
        end
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if ({rv_b, busy_b} !== 2'b00) begin
            errors++; $display("FAIL midop_abandoned: got valid=%0b busy=%0b expected 0 0", rv_b, busy_b);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        v0_a = 1'b0; v1_a = 1'b0; rrdy_a = 1'b0; inc0_a = '0; inc1_a = '0;
        v0_b = 1'b0; v1_b = 1'b0; rrdy_b = 1'b0; inc0_b = '0; inc1_b = '0;
        test_reset();
        test_single();
        test_tie();
        test_backpressure();
        test_settle4();
        test_reset_midop();
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++; $display("FAIL final_queues: got %0d/%0d outstanding, expected 0/0", q_a.size(), q_b.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
